irq_ctrl: RTL and testbench
===========================

# irq_ctrl

Parametrised interrupt controller sitting between peripheral IRQ lines and the accumulator CPU core. Replaces the fixed three-line, toggle-only, first-come logic with N channels, per-channel trigger mode, masking, fixed priority with nesting (in-service tracking plus end-of-interrupt), overrun reporting and a request/acknowledge handshake. The CPU samples O_IRQ_REQ at instruction boundaries, pulses I_ACK when it starts the vector call, and pulses I_EOI from the handler's return path.

## Interface
- CHANNELS, 3: number of IRQ channels, 1..15; channel 0 has the highest priority.
- VEC_BASE, 16'h0000: vector of the reset slot.
- VEC_STRIDE, 2: byte distance between vector slots.
- RISE_MASK, {CHANNELS{1'b0}}: per channel, 1 = rising-edge trigger, 0 = toggle trigger (any level change).

Ports:
- CLOCK  in  1  system clock; all state changes on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- IRQ  in  CHANNELS  raw peripheral request lines; may be asynchronous.
- I_INTF  in  1  CPU interrupt-enable flag.
- I_ACK  in  1  one-cycle pulse: CPU accepts the presented vector.
- I_EOI  in  1  one-cycle pulse: end of the current handler.
- I_MASK_WE  in  1  write strobe for the mask register.
- I_MASK  in  CHANNELS  new mask value; 1 = channel masked.
- I_OVR_CLR  in  1  clears all overrun flags.
- O_IRQ_REQ  out  1  a vector is being presented.
- O_VECTOR  out  16  VEC_BASE + (ch+1)*VEC_STRIDE for the latched channel ch; modulo 2^16.
- O_CHANNEL  out  4  latched channel index.
- O_PENDING  out  CHANNELS  pending bits.
- O_IN_SERVICE  out  CHANNELS  in-service bits.
- O_OVERRUN  out  CHANNELS  sticky overrun flags.
- O_MASK  out  CHANNELS  current mask.

## Operation
- Input path per channel: 2-flop synchroniser, then a previous-value register.
  - Toggle channel event: sync2 != prev.
  - Rising channel event: sync2 & ~prev.
- Event sets the pending bit regardless of mask. Mask only gates requests.
- Event while the pending bit is already 1: event is lost and the overrun bit is set. Overrun bits are sticky until I_OVR_CLR.
- Reset guard: a 2-bit counter suppresses event detection for the first 3 cycles after RESET falls. The synchroniser and prev registers track IRQ during that time, so a line held high through reset raises no request.
- Candidate channel: the lowest index ch with pending[ch] & ~mask[ch], and in_service[j]==0 for every j<=ch. Only strictly higher priority than any in-service channel may nest.
- FSM has two states:
  - IDLE -> REQUEST when I_INTF=1 and a candidate exists. The candidate index is latched into O_CHANNEL and O_VECTOR.
  - REQUEST holds O_IRQ_REQ=1 with the vector stable. A higher-priority arrival does not retarget the request.
  - REQUEST -> IDLE on I_ACK. The pending bit of the latched channel is cleared and its in_service bit is set.
  - REQUEST -> IDLE (withdraw, no bit changes) if I_INTF=0, or the latched channel becomes masked, when no I_ACK is present that cycle.
- I_ACK in IDLE is ignored.
- I_EOI clears the lowest-index set in_service bit; it has no effect if none is set.
- EOI and ACK in the same cycle: the clear is applied first, then the set.
- Event and ACK on the same channel in the same cycle: the pending bit stays 1 (new event) and no overrun is flagged.
- I_MASK_WE loads the mask next edge.
- I_OVR_CLR and a new overrun in the same cycle: the overrun flag ends at 1.

## Timing
- Reset values:
  - O_IRQ_REQ=0, O_VECTOR=VEC_BASE+VEC_STRIDE, O_CHANNEL=0.
  - O_PENDING=0, O_IN_SERVICE=0, O_OVERRUN=0, O_MASK=all ones.
  - FSM=IDLE, guard counter=0.
- Latency, IRQ change sampled at edge t:
  - pending set at edge t+2;
  - FSM enters REQUEST at edge t+3;
  - O_IRQ_REQ high in the cycle after edge t+3 (unmasked, I_INTF=1, no blocking in-service bit).
- After I_ACK at edge a: O_IRQ_REQ is low after edge a. The next request can rise after edge a+1 at the earliest.
- Withdraw takes effect at the edge following the cause.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- RESET asserted mid-REQUEST: all state returns to reset values at that edge. A pending ACK is discarded.

## Test plan
- CHANNELS=3, mask=0, I_INTF=1; IRQ[1] toggles 0->1 at edge 10 -> O_IRQ_REQ=1 after edge 13, O_VECTOR=16'h0004, O_CHANNEL=1; ACK at edge 16 -> O_PENDING=0, O_IN_SERVICE=3'b010.
- With ch1 in service, toggle IRQ[2] then IRQ[0] -> ch2 stays pending with no request; ch0 is requested with vector 16'h0002; after ACK, O_IN_SERVICE=3'b011; EOI -> 3'b010; EOI -> 0, then ch2 is requested with vector 16'h0006.
- RISE_MASK=3'b100: IRQ[2] falls -> no pending; rises -> pending. Toggle mode on ch0: both edges produce events.
- Mask ch0 while REQUEST for ch0 is up -> O_IRQ_REQ drops next edge and pending stays 1; two IRQ[0] toggles 4 cycles apart while masked -> O_OVERRUN[0]=1 until I_OVR_CLR.
- IRQ[0] held high through RESET -> no pending after release; RESET asserted during REQUEST with ACK in the same cycle -> all outputs return to their reset values.
- VEC_BASE=16'hFFFE, VEC_STRIDE=4, ch2 -> O_VECTOR=16'h000A (wrap).

Source files
------------

// File: rtl/irq_ctrl.sv
// Parametrised interrupt controller: synchronised edge/toggle triggers, masking,
// fixed-priority nesting with in-service tracking, overrun flags and a CPU handshake.
module irq_ctrl #(
  parameter int unsigned         CHANNELS   = 3,
  parameter logic [15:0]         VEC_BASE   = 16'h0000,
  parameter int unsigned         VEC_STRIDE = 2,
  parameter logic [CHANNELS-1:0] RISE_MASK  = {CHANNELS{1'b0}}
) (
  input  logic                CLOCK,
  input  logic                RESET,
  input  logic [CHANNELS-1:0] IRQ,
  input  logic                I_INTF,
  input  logic                I_ACK,
  input  logic                I_EOI,
  input  logic                I_MASK_WE,
  input  logic [CHANNELS-1:0] I_MASK,
  input  logic                I_OVR_CLR,
  output logic                O_IRQ_REQ,
  output logic [15:0]         O_VECTOR,
  output logic [3:0]          O_CHANNEL,
  output logic [CHANNELS-1:0] O_PENDING,
  output logic [CHANNELS-1:0] O_IN_SERVICE,
  output logic [CHANNELS-1:0] O_OVERRUN,
  output logic [CHANNELS-1:0] O_MASK
);

  localparam int unsigned CW = 4;
  localparam int unsigned VW = 16;

  typedef enum logic {IDLE, REQUEST} state_t;

  state_t              state;
  logic [CHANNELS-1:0] sync1, sync2, prev;
  logic [CHANNELS-1:0] pending, in_service, overrun, mask;
  logic [1:0]          guard;
  logic [CW-1:0]       channel;
  logic [VW-1:0]       vector;

  logic                guard_done_c;
  logic [CHANNELS-1:0] event_c, sel_c, ack_vec_c, eoi_vec_c;
  logic                ack_c, sel_masked_c;
  logic                cand_valid_c, cand_blocked_c;
  logic [CW-1:0]       cand_idx_c;

  function automatic logic [VW-1:0] vec_of(input logic [CW-1:0] ch);
    logic [31:0] v;
    v = 32'(VEC_BASE) + (32'(ch) + 32'd1) * 32'(VEC_STRIDE);
    return v[VW-1:0];
  endfunction

  // Event detection is held off until the synchroniser has settled after reset
  assign guard_done_c = (guard == 2'd3);

  always_comb begin
    event_c = '0;
    if (guard_done_c)
      event_c = ((sync2 ^ prev) & ~RISE_MASK) | (sync2 & ~prev & RISE_MASK);
  end

  assign sel_c        = CHANNELS'(1) << channel;
  assign sel_masked_c = |(sel_c & mask);
  assign ack_c        = (state == REQUEST) && I_ACK;
  assign ack_vec_c    = ack_c ? sel_c : '0;
  // Lowest set in-service bit is the innermost (highest-priority) active handler
  assign eoi_vec_c    = I_EOI ? (in_service & (~in_service + CHANNELS'(1))) : '0;

  // Any in-service bit at or above a channel's priority blocks it and everything below
  always_comb begin
    cand_valid_c   = 1'b0;
    cand_blocked_c = 1'b0;
    cand_idx_c     = '0;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      cand_blocked_c = cand_blocked_c | in_service[i];
      if (!cand_valid_c && !cand_blocked_c && pending[i] && !mask[i]) begin
        cand_valid_c = 1'b1;
        cand_idx_c   = CW'(i);
      end
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state      <= IDLE;
      sync1      <= '0;
      sync2      <= '0;
      prev       <= '0;
      guard      <= 2'd0;
      pending    <= '0;
      in_service <= '0;
      overrun    <= '0;
      mask       <= '1;
      channel    <= '0;
      vector     <= vec_of('0);
    end else begin
      sync1 <= IRQ;
      sync2 <= sync1;
      prev  <= sync2;
      if (!guard_done_c) guard <= guard + 2'd1;

      // A simultaneous ACK clears the old request, so a new event on that channel is not an overrun
      pending    <= (pending & ~ack_vec_c) | event_c;
      overrun    <= (I_OVR_CLR ? '0 : overrun) | (event_c & pending & ~ack_vec_c);
      in_service <= (in_service & ~eoi_vec_c) | ack_vec_c;
      if (I_MASK_WE) mask <= I_MASK;

      case (state)
        IDLE: begin
          if (I_INTF && cand_valid_c) begin
            state   <= REQUEST;
            channel <= cand_idx_c;
            vector  <= vec_of(cand_idx_c);
          end
        end
        REQUEST: begin
          if (ack_c) state <= IDLE;
          else if (!I_INTF || sel_masked_c) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign O_IRQ_REQ    = (state == REQUEST);
  assign O_VECTOR     = vector;
  assign O_CHANNEL    = channel;
  assign O_PENDING    = pending;
  assign O_IN_SERVICE = in_service;
  assign O_OVERRUN    = overrun;
  assign O_MASK       = mask;

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: directed scenarios plus randomized traffic compared against a
// rule-level reference model (input history, priority cut-off, handshake rules).
module tb_irq_ctrl;

  localparam int unsigned     CH = 3;
  localparam logic [15:0]     VB = 16'hFFFE;
  localparam int unsigned     VS = 4;
  localparam logic [CH-1:0]   RM = 3'b100;
  localparam logic [32:0]     RST_BUS = {1'b0, 16'h0002, 4'h0, 3'b000, 3'b000, 3'b000, 3'b111};

  logic          CLOCK = 1'b0;
  logic          RESET = 1'b1;
  logic [CH-1:0] IRQ = '0;
  logic          I_INTF = 1'b0, I_ACK = 1'b0, I_EOI = 1'b0;
  logic          I_MASK_WE = 1'b0, I_OVR_CLR = 1'b0;
  logic [CH-1:0] I_MASK = '0;
  logic          O_IRQ_REQ;
  logic [15:0]   O_VECTOR;
  logic [3:0]    O_CHANNEL;
  logic [CH-1:0] O_PENDING, O_IN_SERVICE, O_OVERRUN, O_MASK;

  int checks = 0;
  int errors = 0;

  irq_ctrl #(.CHANNELS(CH), .VEC_BASE(VB), .VEC_STRIDE(VS), .RISE_MASK(RM)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .IRQ(IRQ), .I_INTF(I_INTF), .I_ACK(I_ACK),
    .I_EOI(I_EOI), .I_MASK_WE(I_MASK_WE), .I_MASK(I_MASK), .I_OVR_CLR(I_OVR_CLR),
    .O_IRQ_REQ(O_IRQ_REQ), .O_VECTOR(O_VECTOR), .O_CHANNEL(O_CHANNEL),
    .O_PENDING(O_PENDING), .O_IN_SERVICE(O_IN_SERVICE), .O_OVERRUN(O_OVERRUN),
    .O_MASK(O_MASK)
  );

  always #5 CLOCK = ~CLOCK;

  // Reference model state
  logic          m_req;
  logic [15:0]   m_vec;
  int            m_chi;
  logic [CH-1:0] m_pend, m_isr, m_ovr, m_mask;
  logic [CH-1:0] h0, h1, h2;
  int            m_since;

  logic [32:0] dut_bus, mdl_bus;
  assign dut_bus = {O_IRQ_REQ, O_VECTOR, O_CHANNEL, O_PENDING, O_IN_SERVICE, O_OVERRUN, O_MASK};
  assign mdl_bus = {m_req, m_vec, 4'(m_chi), m_pend, m_isr, m_ovr, m_mask};

  function automatic logic [15:0] exp_vec(input int ch);
    return 16'((int'(VB) + (ch + 1) * int'(VS)) % 65536);
  endfunction

  // h0/h1/h2 hold the last three sampled IRQ values; an event compares the samples
  // taken two and three edges ago, and is ignored for the first three edges after reset.
  always @(posedge CLOCK) begin : ref_model
    logic [CH-1:0] ev, ackv, eoiv;
    int top_isr, cand;
    if (RESET) begin
      m_req = 1'b0; m_chi = 0; m_vec = exp_vec(0);
      m_pend = '0; m_isr = '0; m_ovr = '0; m_mask = '1;
      h0 = '0; h1 = '0; h2 = '0; m_since = 0;
    end else begin
      ev = '0;
      if (m_since >= 3)
        for (int c = 0; c < CH; c++)
          ev[c] = RM[c] ? (h1[c] & ~h2[c]) : (h1[c] ^ h2[c]);
      ackv = '0;
      if (m_req && I_ACK) ackv = CH'(1) << m_chi;
      top_isr = CH;
      for (int c = CH - 1; c >= 0; c--) if (m_isr[c]) top_isr = c;
      eoiv = (I_EOI && top_isr < CH) ? CH'(1) << top_isr : '0;
      cand = -1;
      for (int c = top_isr - 1; c >= 0; c--) if (m_pend[c] && !m_mask[c]) cand = c;
      if (!m_req) begin
        if (I_INTF && cand >= 0) begin m_req = 1'b1; m_chi = cand; m_vec = exp_vec(cand); end
      end else if (I_ACK) m_req = 1'b0;
      else if (!I_INTF || m_mask[m_chi]) m_req = 1'b0;
      m_ovr  = (I_OVR_CLR ? '0 : m_ovr) | (ev & m_pend & ~ackv);
      m_pend = (m_pend & ~ackv) | ev;
      m_isr  = (m_isr & ~eoiv) | ackv;
      if (I_MASK_WE) m_mask = I_MASK;
      h2 = h1; h1 = h0; h0 = IRQ;
      if (m_since < 3) m_since++;
    end
  end

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic test_reset();
    RESET = 1'b1; IRQ = 3'b001;
    tick(); tick();
    checks++; if (dut_bus !== RST_BUS) begin errors++; $display("FAIL reset_values: got %h want %h", dut_bus, RST_BUS); end
    RESET = 1'b0;
    repeat (8) tick();
    checks++; if (O_PENDING !== 3'b000) begin errors++; $display("FAIL reset_held_line: pending got %b want 000", O_PENDING); end
    checks++; if (dut_bus !== mdl_bus) begin errors++; $display("FAIL reset_model: got %h want %h", dut_bus, mdl_bus); end
  endtask

  task automatic test_basic();
    I_MASK = '0; I_MASK_WE = 1'b1; I_INTF = 1'b1;
    tick();
    I_MASK_WE = 1'b0;
    IRQ[1] = 1'b1;
    repeat (3) tick();
    checks++; if (O_PENDING !== 3'b010 || O_IRQ_REQ !== 1'b0) begin errors++; $display("FAIL basic_pending: got pend %b req %b want 010 0", O_PENDING, O_IRQ_REQ); end
    tick();
    checks++; if (O_IRQ_REQ !== 1'b1 || O_CHANNEL !== 4'd1 || O_VECTOR !== 16'h0006) begin errors++; $display("FAIL basic_request: got req %b ch %0d vec %h want 1 1 0006", O_IRQ_REQ, O_CHANNEL, O_VECTOR); end
    I_ACK = 1'b1; tick(); I_ACK = 1'b0;
    checks++; if (O_PENDING !== 3'b000 || O_IN_SERVICE !== 3'b010 || O_IRQ_REQ !== 1'b0) begin errors++; $display("FAIL basic_ack: got pend %b isr %b req %b want 000 010 0", O_PENDING, O_IN_SERVICE, O_IRQ_REQ); end
    checks++; if (dut_bus !== mdl_bus) begin errors++; $display("FAIL basic_model: got %h want %h", dut_bus, mdl_bus); end
  endtask

  task automatic test_nesting();
    IRQ[2] = 1'b1;
    repeat (6) tick();
    checks++; if (O_PENDING !== 3'b100 || O_IRQ_REQ !== 1'b0) begin errors++; $display("FAIL nest_blocked: got pend %b req %b want 100 0", O_PENDING, O_IRQ_REQ); end
    IRQ[0] = 1'b0;
    repeat (4) tick();
    checks++; if (O_IRQ_REQ !== 1'b1 || O_CHANNEL !== 4'd0 || O_VECTOR !== 16'h0002) begin errors++; $display("FAIL nest_ch0: got req %b ch %0d vec %h want 1 0 0002", O_IRQ_REQ, O_CHANNEL, O_VECTOR); end
    I_ACK = 1'b1; tick(); I_ACK = 1'b0;
    checks++; if (O_IN_SERVICE !== 3'b011) begin errors++; $display("FAIL nest_isr2: got %b want 011", O_IN_SERVICE); end
    I_EOI = 1'b1; tick(); I_EOI = 1'b0;
    checks++; if (O_IN_SERVICE !== 3'b010 || O_IRQ_REQ !== 1'b0) begin errors++; $display("FAIL nest_eoi1: got isr %b req %b want 010 0", O_IN_SERVICE, O_IRQ_REQ); end
    I_EOI = 1'b1; tick(); I_EOI = 1'b0;
    checks++; if (O_IN_SERVICE !== 3'b000) begin errors++; $display("FAIL nest_eoi2: got %b want 000", O_IN_SERVICE); end
    tick();
    checks++; if (O_IRQ_REQ !== 1'b1 || O_CHANNEL !== 4'd2 || O_VECTOR !== 16'h000A) begin errors++; $display("FAIL nest_ch2_wrap: got req %b ch %0d vec %h want 1 2 000A", O_IRQ_REQ, O_CHANNEL, O_VECTOR); end
    I_ACK = 1'b1; tick(); I_ACK = 1'b0;
    I_EOI = 1'b1; tick(); I_EOI = 1'b0;
    checks++; if (dut_bus !== mdl_bus) begin errors++; $display("FAIL nest_model: got %h want %h", dut_bus, mdl_bus); end
  endtask

  task automatic test_trigger_modes();
    I_INTF = 1'b0;
    IRQ[2] = 1'b0;
    repeat (6) tick();
    checks++; if (O_PENDING !== 3'b000) begin errors++; $display("FAIL rise_fall_ignored: got %b want 000", O_PENDING); end
    IRQ[2] = 1'b1;
    repeat (6) tick();
    checks++; if (O_PENDING !== 3'b100) begin errors++; $display("FAIL rise_detect: got %b want 100", O_PENDING); end
    IRQ[0] = 1'b1;
    repeat (6) tick();
    checks++; if (O_PENDING !== 3'b101 || O_OVERRUN !== 3'b000) begin errors++; $display("FAIL toggle_rise: got pend %b ovr %b want 101 000", O_PENDING, O_OVERRUN); end
    IRQ[0] = 1'b0;
    repeat (6) tick();
    checks++; if (O_OVERRUN !== 3'b001) begin errors++; $display("FAIL toggle_fall: got ovr %b want 001", O_OVERRUN); end
    I_OVR_CLR = 1'b1; tick(); I_OVR_CLR = 1'b0;
    I_INTF = 1'b1; tick();
    checks++; if (O_IRQ_REQ !== 1'b1 || O_CHANNEL !== 4'd0) begin errors++; $display("FAIL modes_prio: got req %b ch %0d want 1 0", O_IRQ_REQ, O_CHANNEL); end
    I_ACK = 1'b1; tick(); I_ACK = 1'b0;
    I_EOI = 1'b1; tick(); I_EOI = 1'b0;
    tick();
    checks++; if (O_IRQ_REQ !== 1'b1 || O_CHANNEL !== 4'd2) begin errors++; $display("FAIL modes_ch2: got req %b ch %0d want 1 2", O_IRQ_REQ, O_CHANNEL); end
    I_ACK = 1'b1; tick(); I_ACK = 1'b0;
    I_EOI = 1'b1; tick(); I_EOI = 1'b0;
    checks++; if (dut_bus !== mdl_bus) begin errors++; $display("FAIL modes_model: got %h want %h", dut_bus, mdl_bus); end
  endtask

  task automatic test_mask_overrun();
    IRQ[0] = 1'b1;
    repeat (4) tick();
    checks++; if (O_IRQ_REQ !== 1'b1 || O_CHANNEL !== 4'd0) begin errors++; $display("FAIL mask_req: got req %b ch %0d want 1 0", O_IRQ_REQ, O_CHANNEL); end
    I_MASK = 3'b001; I_MASK_WE = 1'b1; tick(); I_MASK_WE = 1'b0;
    checks++; if (O_MASK !== 3'b001 || O_IRQ_REQ !== 1'b1) begin errors++; $display("FAIL mask_load: got mask %b req %b want 001 1", O_MASK, O_IRQ_REQ); end
    tick();
    checks++; if (O_IRQ_REQ !== 1'b0 || O_PENDING !== 3'b001) begin errors++; $display("FAIL mask_withdraw: got req %b pend %b want 0 001", O_IRQ_REQ, O_PENDING); end
    IRQ[0] = 1'b0; repeat (4) tick();
    IRQ[0] = 1'b1; repeat (7) tick();
    checks++; if (O_OVERRUN !== 3'b001 || O_IRQ_REQ !== 1'b0) begin errors++; $display("FAIL mask_overrun: got ovr %b req %b want 001 0", O_OVERRUN, O_IRQ_REQ); end
    I_OVR_CLR = 1'b1; tick(); I_OVR_CLR = 1'b0;
    checks++; if (O_OVERRUN !== 3'b000) begin errors++; $display("FAIL ovr_clear: got %b want 000", O_OVERRUN); end
    I_MASK = 3'b000; I_MASK_WE = 1'b1; tick(); I_MASK_WE = 1'b0;
    tick();
    checks++; if (O_IRQ_REQ !== 1'b1 || O_CHANNEL !== 4'd0) begin errors++; $display("FAIL unmask_req: got req %b ch %0d want 1 0", O_IRQ_REQ, O_CHANNEL); end
    I_ACK = 1'b1; tick(); I_ACK = 1'b0;
    I_EOI = 1'b1; tick(); I_EOI = 1'b0;
    checks++; if (dut_bus !== mdl_bus) begin errors++; $display("FAIL mask_model: got %h want %h", dut_bus, mdl_bus); end
  endtask

  task automatic test_back_to_back();
    IRQ[1] = ~IRQ[1];
    repeat (4) tick();
    I_ACK = 1'b1; tick(); I_ACK = 1'b0;
    IRQ[0] = ~IRQ[0];
    repeat (4) tick();
    checks++; if (O_IRQ_REQ !== 1'b1 || O_CHANNEL !== 4'd0) begin errors++; $display("FAIL b2b_nest_req: got req %b ch %0d want 1 0", O_IRQ_REQ, O_CHANNEL); end
    I_ACK = 1'b1; I_EOI = 1'b1; tick(); I_ACK = 1'b0; I_EOI = 1'b0;
    checks++; if (O_IN_SERVICE !== 3'b001) begin errors++; $display("FAIL b2b_eoi_ack: got isr %b want 001", O_IN_SERVICE); end
    I_EOI = 1'b1; tick(); I_EOI = 1'b0;
    IRQ[1] = ~IRQ[1];
    repeat (4) tick();
    IRQ[1] = ~IRQ[1];
    tick(); tick();
    I_ACK = 1'b1; tick(); I_ACK = 1'b0;
    checks++; if (O_PENDING !== 3'b010 || O_OVERRUN !== 3'b000 || O_IN_SERVICE !== 3'b010) begin errors++; $display("FAIL b2b_event_ack: got pend %b ovr %b isr %b want 010 000 010", O_PENDING, O_OVERRUN, O_IN_SERVICE); end
    I_EOI = 1'b1; tick(); I_EOI = 1'b0;
    tick();
    checks++; if (O_IRQ_REQ !== 1'b1 || O_CHANNEL !== 4'd1) begin errors++; $display("FAIL b2b_rerequest: got req %b ch %0d want 1 1", O_IRQ_REQ, O_CHANNEL); end
    I_ACK = 1'b1; tick(); I_ACK = 1'b0;
    I_EOI = 1'b1; tick(); I_EOI = 1'b0;
    checks++; if (dut_bus !== mdl_bus) begin errors++; $display("FAIL b2b_model: got %h want %h", dut_bus, mdl_bus); end
  endtask

  task automatic test_reset_mid_request();
    IRQ[1] = ~IRQ[1];
    repeat (4) tick();
    checks++; if (O_IRQ_REQ !== 1'b1) begin errors++; $display("FAIL midrst_req: got %b want 1", O_IRQ_REQ); end
    RESET = 1'b1; I_ACK = 1'b1; tick(); I_ACK = 1'b0;
    checks++; if (dut_bus !== RST_BUS) begin errors++; $display("FAIL midrst_values: got %h want %h", dut_bus, RST_BUS); end
    RESET = 1'b0;
    repeat (8) tick();
    checks++; if (dut_bus !== mdl_bus) begin errors++; $display("FAIL midrst_model: got %h want %h", dut_bus, mdl_bus); end
  endtask

  task automatic test_random();
    I_MASK = 3'b000; I_MASK_WE = 1'b1; tick(); I_MASK_WE = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < CH; c++) if ($urandom_range(7) == 0) IRQ[c] = ~IRQ[c];
      I_INTF    = ($urandom_range(7) != 0);
      I_ACK     = ($urandom_range(2) == 0);
      I_EOI     = ($urandom_range(5) == 0);
      I_MASK_WE = ($urandom_range(19) == 0);
      I_MASK    = CH'($urandom_range(7)) & CH'($urandom_range(7));
      I_OVR_CLR = ($urandom_range(24) == 0);
      RESET     = ($urandom_range(399) == 0);
      tick();
      checks++; if (dut_bus !== mdl_bus) begin errors++; $display("FAIL random_cycle%0d: got %h want %h", n, dut_bus, mdl_bus); end
    end
    RESET = 1'b0; I_ACK = 1'b0; I_EOI = 1'b0; I_MASK_WE = 1'b0; I_OVR_CLR = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_nesting();
    test_trigger_modes();
    test_mask_overrun();
    test_back_to_back();
    test_reset_mid_request();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
